// File: rtl/consent_header_serializer_if.sv
// Header field capture and byte-stream signals of the consent header serializer.
// The master side is the packet source plus the downstream framer.
// The slave side is the serializer itself.
interface consent_header_serializer_if;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [31:0] rpp_address;
  logic [15:0] origin_id;
  logic [7:0]  consent_byte;
  logic [4:0]  phase_entropy_index;
  logic [2:0]  complecount_trace;
  logic [7:0]  payload_type;
  logic [7:0]  fallback_vector;
  logic [15:0] coherence_window_id;
  logic [7:0]  phase_byte;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output hdr_valid, rpp_address, origin_id, consent_byte, phase_entropy_index,
           complecount_trace, payload_type, fallback_vector, coherence_window_id,
           phase_byte, out_ready,
    input  hdr_ready, out_byte, out_valid, out_last
  );

  modport slave (
    input  hdr_valid, rpp_address, origin_id, consent_byte, phase_entropy_index,
           complecount_trace, payload_type, fallback_vector, coherence_window_id,
           phase_byte, out_ready,
    output hdr_ready, out_byte, out_valid, out_last
  );
endinterface

// File: rtl/consent_header_serializer.sv
// Builds the 18-byte consent header (fields, packet ID, CRC-8) and streams it MSB byte first.
// Latency: first byte valid the cycle after capture; 18 beats, next capture one cycle after the last beat.
// Backpressure: out_ready low freezes byte, last flag, index and CRC; hdr_ready is low for the whole packet.
module consent_header_serializer #(
  parameter logic [31:0] PKT_ID_INIT = 32'h0000_0001,
  parameter logic [7:0]  CRC_INIT    = 8'h00
) (
  input  logic                        clk,
  input  logic                        rst_n,
  consent_header_serializer_if.slave  bus,
  output logic [31:0]                 pkt_id_next,
  output logic                        busy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [4:0] LAST_IDX = 5'd17;
  localparam logic [4:0] CRC_PREV = 5'd16;

  state_t       state_q, state_d;
  logic [135:0] shadow_q, shadow_d;
  logic [4:0]   idx_q, idx_d;
  logic [7:0]   crc_q, crc_d;
  logic [31:0]  pkt_id_q, pkt_id_d;
  logic [7:0]   out_byte_q, out_byte_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic         busy_q, busy_d;
  logic         hdr_ready_q, hdr_ready_d;
  logic [7:0]   crc_next;

  // CRC-8, polynomial 0x07, MSB first, one byte unrolled into eight shift steps.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Byte idx of the shadow register, byte 0 being the most significant.
  function automatic logic [7:0] shadow_byte(input logic [135:0] sh, input logic [4:0] idx);
    logic [135:0] s;
    s = sh << {idx, 3'b000};
    return s[135:128];
  endfunction

  // Next-state logic: capture in IDLE, advance one byte per accepted beat in SEND.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    idx_d       = idx_q;
    crc_d       = crc_q;
    pkt_id_d    = pkt_id_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    hdr_ready_d = hdr_ready_q;
    crc_next    = crc8_update(crc_q, out_byte_q);
    case (state_q)
      IDLE: begin
        if (bus.hdr_valid && hdr_ready_q) begin
          shadow_d    = {bus.rpp_address, pkt_id_q, bus.origin_id, bus.consent_byte,
                         bus.phase_entropy_index, bus.complecount_trace, bus.payload_type,
                         bus.fallback_vector, bus.coherence_window_id, bus.phase_byte};
          pkt_id_d    = pkt_id_q + 32'd1;
          crc_d       = CRC_INIT;
          idx_d       = 5'd0;
          out_byte_d  = bus.rpp_address[31:24];
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          busy_d      = 1'b1;
          hdr_ready_d = 1'b0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (out_valid_q && bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d       = 5'd0;
            out_byte_d  = 8'h00;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            hdr_ready_d = 1'b1;
            state_d     = IDLE;
          end else begin
            crc_d = crc_next;
            idx_d = idx_q + 5'd1;
            if (idx_q == CRC_PREV) begin
              // Byte 16 just went out: the updated CRC is the trailer byte.
              out_byte_d = crc_next;
              out_last_d = 1'b1;
            end else begin
              out_byte_d = shadow_byte(shadow_q, idx_q + 5'd1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      idx_q       <= '0;
      crc_q       <= CRC_INIT;
      pkt_id_q    <= PKT_ID_INIT;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      hdr_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      crc_q       <= crc_d;
      pkt_id_q    <= pkt_id_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      hdr_ready_q <= hdr_ready_d;
    end
  end

  assign bus.hdr_ready = hdr_ready_q;
  assign bus.out_byte  = out_byte_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign pkt_id_next   = pkt_id_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_consent_header_serializer.sv
// Bench for consent_header_serializer: directed packets, scoreboard queue of expected beats.
// A monitor pops and compares each accepted beat and checks stall stability.
// A second instance with an all-ones initial packet ID covers the ID wrap.
module tb_consent_header_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  consent_header_serializer_if a_if ();
  consent_header_serializer_if w_if ();
  logic [31:0] a_pid, w_pid;
  logic        a_busy, w_busy;

  consent_header_serializer #(.PKT_ID_INIT(32'h0000_0000), .CRC_INIT(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .bus(a_if), .pkt_id_next(a_pid), .busy(a_busy)
  );

  consent_header_serializer #(.PKT_ID_INIT(32'hFFFF_FFFF), .CRC_INIT(8'h00)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(w_if), .pkt_id_next(w_pid), .busy(w_busy)
  );

  typedef struct packed {
    logic [31:0] rpp;
    logic [15:0] org;
    logic [7:0]  cons;
    logic [4:0]  ent;
    logic [2:0]  cc;
    logic [7:0]  pt;
    logic [7:0]  fb;
    logic [15:0] cw;
    logic [7:0]  ph;
  } fld_t;

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_q[$];
  logic [7:0] rx[$];
  logic [7:0] wrx[$];
  logic [7:0] exp_hdr[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference CRC over the 136-bit message.
  function automatic logic [7:0] crc_model(input logic [135:0] m);
    logic [7:0] r;
    logic fbk;
    r = 8'h00;
    for (int i = 135; i >= 0; i--) begin
      fbk = r[7] ^ m[i];
      r = {r[6:0], 1'b0};
      if (fbk) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic build(input fld_t f, input logic [31:0] pid);
    logic [135:0] m;
    m = {f.rpp, pid, f.org, f.cons, f.ent, f.cc, f.pt, f.fb, f.cw, f.ph};
    for (int i = 0; i < 17; i++) exp_hdr[i] = m[135 - 8*i -: 8];
    exp_hdr[17] = crc_model(m);
  endtask

  task automatic push_exp();
    for (int i = 0; i < 18; i++) exp_q.push_back({(i == 17), exp_hdr[i]});
  endtask

  task automatic drive_fields(input fld_t f);
    a_if.rpp_address         = f.rpp;
    a_if.origin_id           = f.org;
    a_if.consent_byte        = f.cons;
    a_if.phase_entropy_index = f.ent;
    a_if.complecount_trace   = f.cc;
    a_if.payload_type        = f.pt;
    a_if.fallback_vector     = f.fb;
    a_if.coherence_window_id = f.cw;
    a_if.phase_byte          = f.ph;
  endtask

  task automatic scramble_fields();
    fld_t j;
    j = '0;
    j.rpp = $urandom;
    j.org = 16'($urandom);
    j.ph  = 8'($urandom);
    j.cw  = 16'($urandom);
    drive_fields(j);
  endtask

  // One-cycle hdr_valid pulse, then garbage on the fields to prove the shadow is frozen.
  task automatic capture(input fld_t f);
    @(posedge clk); #1;
    drive_fields(f);
    a_if.hdr_valid = 1'b1;
    @(negedge clk);
    check("hdr_ready_idle", a_if.hdr_ready, 1);
    @(posedge clk); #1;
    a_if.hdr_valid = 1'b0;
    scramble_fields();
  endtask

  task automatic run_pkt(input bit stall, input int n_beats);
    int acc = 0;
    int cyc = 0;
    bit bad = 0;
    while (acc < n_beats && cyc < 200) begin
      a_if.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (!(a_if.out_valid && a_busy && !a_if.hdr_ready)) bad = 1;
      if (a_if.out_valid && a_if.out_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    check("send_flags", bad, 0);
    if (acc < n_beats) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", acc, n_beats);
    end
    a_if.out_ready = 1'b1;
  endtask

  task automatic check_idle(input string name);
    check(name, {a_if.hdr_ready, a_if.out_valid, a_if.out_last, a_busy}, 4'b1000);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    exp_q.delete();
    #10;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: compare every accepted beat, and hold stability across stalls.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;
  logic       prev_last  = 1'b0;
  logic [8:0] mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {a_if.out_valid, a_if.out_last, a_if.out_byte}, {1'b1, prev_last, prev_byte});
      if (a_if.out_valid && a_if.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got byte %0h expected no beat", a_if.out_byte);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat", {a_if.out_last, a_if.out_byte}, mon_e);
          rx.push_back(a_if.out_byte);
        end
      end
      prev_stall = a_if.out_valid && !a_if.out_ready;
      prev_byte  = a_if.out_byte;
      prev_last  = a_if.out_last;
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_if.out_valid && w_if.out_ready) wrx.push_back(w_if.out_byte);
  end

  fld_t f0, f3, f5a, f5b;
  logic [7:0] t3 [17];
  logic [7:0] b11;

  initial begin
    f0 = '0;
    drive_fields(f0);
    a_if.hdr_valid = 1'b0;
    a_if.out_ready = 1'b1;
    w_if.hdr_valid = 1'b0;
    w_if.out_ready = 1'b1;
    w_if.rpp_address = '0; w_if.origin_id = '0; w_if.consent_byte = '0;
    w_if.phase_entropy_index = '0; w_if.complecount_trace = '0; w_if.payload_type = '0;
    w_if.fallback_vector = '0; w_if.coherence_window_id = '0; w_if.phase_byte = '0;

    // Reset state
    #12;
    check("rst_flags", {a_if.hdr_ready, a_if.out_valid, a_if.out_last, a_busy}, 4'b1000);
    check("rst_byte", a_if.out_byte, 8'h00);
    check("rst_pid", a_pid, 32'h0);
    check("rst_pid_wrap", w_pid, 32'hFFFF_FFFF);
    #11;
    rst_n = 1'b1;

    // Packet ID wrap on the second instance, two back-to-back captures
    @(posedge clk); #1;
    w_if.hdr_valid = 1'b1;
    @(posedge clk); #1;
    check("wrap_pid_after_1", w_pid, 32'h0);
    for (int k = 0; k < 19; k++) @(posedge clk);
    #1;
    check("wrap_pid_after_2", w_pid, 32'h1);
    w_if.hdr_valid = 1'b0;
    for (int k = 0; k < 40 && wrx.size() < 36; k++) @(posedge clk);
    check("wrap_beats", wrx.size(), 36);
    if (wrx.size() >= 36) begin
      check("wrap_id_first", {wrx[4], wrx[5], wrx[6], wrx[7]}, 32'hFFFF_FFFF);
      check("wrap_id_second", {wrx[22], wrx[23], wrx[24], wrx[25]}, 32'h0);
    end

    // Test 1: all-zero header, packet ID 0
    build(f0, 32'h0);
    for (int i = 0; i < 18; i++) exp_hdr[i] = 8'h00;
    push_exp();
    capture(f0);
    run_pkt(1'b0, 18);
    check_idle("t1_idle_after_last");
    check("t1_pid_next", a_pid, 32'h1);

    // Test 2: single phase_byte bit, hand CRC values
    do_reset();
    f0.ph = 8'h01;
    build(f0, 32'h0);
    exp_hdr[16] = 8'h01;
    exp_hdr[17] = 8'h07;
    push_exp();
    capture(f0);
    run_pkt(1'b0, 18);
    check_idle("t2a_idle");
    do_reset();
    f0.ph = 8'h80;
    build(f0, 32'h0);
    exp_hdr[16] = 8'h80;
    exp_hdr[17] = 8'h89;
    push_exp();
    capture(f0);
    run_pkt(1'b0, 18);
    check_idle("t2b_idle");

    // Test 3: realistic header with packet ID 1
    f3 = '{rpp: 32'h4250_0000, org: 16'h0010, cons: 8'hF0, ent: 5'd5, cc: 3'd3,
           pt: 8'h01, fb: 8'h2A, cw: 16'h0042, ph: 8'h00};
    t3 = '{8'h42, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
           8'h10, 8'hF0, 8'h2B, 8'h01, 8'h2A, 8'h00, 8'h42, 8'h00};
    build(f3, 32'h1);
    for (int i = 0; i < 17; i++) exp_hdr[i] = t3[i];
    push_exp();
    rx.delete();
    capture(f3);
    run_pkt(1'b0, 18);
    check_idle("t3_idle");
    check("t3_rx_len", rx.size(), 18);
    if (rx.size() == 18) begin
      b11 = rx[11];
      check("t3_parse_rpp", {rx[0], rx[1], rx[2], rx[3]}, f3.rpp);
      check("t3_parse_pid", {rx[4], rx[5], rx[6], rx[7]}, 32'h1);
      check("t3_parse_org", {rx[8], rx[9]}, f3.org);
      check("t3_parse_ent_cc", {b11[7:3], b11[2:0]}, {f3.ent, f3.cc});
      check("t3_parse_cw", {rx[14], rx[15]}, f3.cw);
      check("t3_parse_crc", rx[17], crc_model({f3.rpp, 32'h1, f3.org, f3.cons, f3.ent,
                                               f3.cc, f3.pt, f3.fb, f3.cw, f3.ph}));
    end

    // Test 4: same packet under random back-pressure (packet ID 2)
    build(f3, 32'h2);
    push_exp();
    capture(f3);
    run_pkt(1'b1, 18);
    check_idle("t4_idle");

    // Test 5: hdr_valid held high across two packets (IDs 3 and 4)
    f5a = f3;
    f5a.rpp = 32'hA1B2_C3D4;
    f5b = f3;
    f5b.rpp = 32'h0F1E_2D3C;
    f5b.ph  = 8'h5A;
    build(f5a, 32'h3);
    push_exp();
    build(f5b, 32'h4);
    push_exp();
    @(posedge clk); #1;
    drive_fields(f5a);
    a_if.hdr_valid = 1'b1;
    a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    drive_fields(f5b);
    begin
      bit bad = 0;
      for (int k = 0; k < 18; k++) begin
        @(negedge clk);
        if (a_if.hdr_ready) bad = 1;
        @(posedge clk);
      end
      @(negedge clk);
      check("t5_ready_low_18", bad, 0);
      check("t5_ready_at_19", a_if.hdr_ready, 1);
    end
    @(posedge clk); #1;
    a_if.hdr_valid = 1'b0;
    check("t5_pid_next", a_pid, 32'h5);
    run_pkt(1'b0, 18);
    check_idle("t5_idle");

    // Test 6: asynchronous reset while byte 9 is presented
    build(f3, 32'h5);
    push_exp();
    capture(f3);
    run_pkt(1'b0, 9);
    check("t6_byte9", a_if.out_byte, exp_hdr[9]);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_abort_flags", {a_if.hdr_ready, a_if.out_valid, a_if.out_last, a_busy}, 4'b1000);
    check("t6_abort_byte", a_if.out_byte, 8'h00);
    check("t6_abort_pid", a_pid, 32'h0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    check("t6_pid_after_release", a_pid, 32'h0);
    build(f3, 32'h0);
    push_exp();
    capture(f3);
    run_pkt(1'b0, 18);
    check_idle("t6_idle");

    @(posedge clk); #1;
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
